// File: rtl/vreducesum_arbiter.sv
// Round-robin front end for a shared vreducesum reducer.
// Grants one requester per cycle, registers its vector onto pipe_x, and
// carries the requester id through a shadow tag pipeline that lines up
// with the reducer depth so each sum is returned to its originator.
module vreducesum_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int VECTOR_SIZE = 16,
  parameter int INT_SIZE    = 16
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic [NUM_REQ-1:0]                      req_valid,
  output logic [NUM_REQ-1:0]                      req_ready,
  input  logic [NUM_REQ*VECTOR_SIZE*INT_SIZE-1:0] req_x,
  output logic [VECTOR_SIZE*INT_SIZE-1:0]         pipe_x,
  input  logic [INT_SIZE-1:0]                     pipe_y,
  output logic [NUM_REQ-1:0]                      resp_valid,
  output logic [INT_SIZE-1:0]                     resp_data,
  output logic                                    busy,
  output logic [$clog2($clog2(VECTOR_SIZE)+3)-1:0] inflight
);

  localparam int LAT  = $clog2(VECTOR_SIZE);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int VW   = VECTOR_SIZE * INT_SIZE;
  localparam int CW   = $clog2(LAT + 3);

  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] w_gid;
  logic [ID_W-1:0] w_ptr_nxt;
  logic [ID_W:0]   w_idx;
  logic            w_found;

  logic [LAT:0]    r_tag_vld;
  logic [ID_W-1:0] r_tag_id [LAT+1];
  logic [NUM_REQ-1:0] w_resp_onehot;

  // Round-robin search: first valid requester at or after the pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_gid   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (w_idx >= (ID_W+1)'(NUM_REQ)) begin
        w_idx = w_idx - (ID_W+1)'(NUM_REQ);
      end
      if (!w_found && req_valid[w_idx[ID_W-1:0]]) begin
        w_found = 1'b1;
        w_gid   = w_idx[ID_W-1:0];
      end
    end
    // Nothing is accepted while reset is held.
    if (reset) begin
      w_found = 1'b0;
    end
  end

  // One-hot grant and the pointer value that follows the winner.
  always_comb begin
    req_ready = '0;
    if (w_found) begin
      req_ready[w_gid] = 1'b1;
    end
    w_ptr_nxt = (w_gid == ID_W'(NUM_REQ - 1)) ? '0 : w_gid + 1'b1;
  end

  // Priority pointer advances past the winner only on an accept.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  // Stage 0: registered vector into the reducer; zeros on idle cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      pipe_x <= '0;
    end else if (w_found) begin
      pipe_x <= req_x[int'(w_gid)*VW +: VW];
    end else begin
      pipe_x <= '0;
    end
  end

  // Stages 0..LAT: tag shadow pipeline, no stall since the reducer never back-pressures.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tag_vld <= '0;
      for (int k = 0; k <= LAT; k++) begin
        r_tag_id[k] <= '0;
      end
    end else begin
      r_tag_vld   <= {r_tag_vld[LAT-1:0], w_found};
      r_tag_id[0] <= w_gid;
      for (int k = 1; k <= LAT; k++) begin
        r_tag_id[k] <= r_tag_id[k-1];
      end
    end
  end

  // Decode the id leaving the last tag stage.
  always_comb begin
    w_resp_onehot = '0;
    w_resp_onehot[r_tag_id[LAT]] = 1'b1;
  end

  // Result return: strobe the originator for one cycle; data holds when idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid <= '0;
      resp_data  <= '0;
    end else if (r_tag_vld[LAT]) begin
      resp_valid <= w_resp_onehot;
      resp_data  <= pipe_y;
    end else begin
      resp_valid <= '0;
    end
  end

  // Occupancy: count of valid tag stages.
  always_comb begin
    inflight = '0;
    for (int k = 0; k <= LAT; k++) begin
      inflight = inflight + CW'(r_tag_vld[k]);
    end
    busy = |r_tag_vld;
  end

endmodule

// File: tb/tb_vreducesum_arbiter.sv
// Bench for vreducesum_arbiter with a behavioural reducer model and a
// response scoreboard keyed on accept order, id, sum and arrival cycle.
module tb_vreducesum_arbiter;

  localparam int NUM_REQ = 4;
  localparam int VECTOR_SIZE = 16;
  localparam int INT_SIZE = 16;
  localparam int LAT = 4;
  localparam int VW = VECTOR_SIZE * INT_SIZE;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    req_valid;
  logic [3:0]    req_ready;
  logic [1023:0] req_x;
  logic [255:0]  pipe_x;
  logic [15:0]   pipe_y;
  logic [3:0]    resp_valid;
  logic [15:0]   resp_data;
  logic          busy;
  logic [2:0]    inflight;

  vreducesum_arbiter #(
    .NUM_REQ(NUM_REQ), .VECTOR_SIZE(VECTOR_SIZE), .INT_SIZE(INT_SIZE)
  ) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .pipe_x(pipe_x), .pipe_y(pipe_y), .resp_valid(resp_valid),
    .resp_data(resp_data), .busy(busy), .inflight(inflight)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          id;
    logic [15:0] sum;
    int          due;
  } sb_t;

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  exp_ready;
    logic [15:0] base;
  } vec_t;

  sb_t  sb[$];
  vec_t tbl[12];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_resp = 0;
  logic [15:0] red [LAT];

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [15:0] vsum(input logic [255:0] v);
    logic [15:0] s;
    s = '0;
    for (int e = 0; e < VECTOR_SIZE; e++) s = s + v[e*16 +: 16];
    return s;
  endfunction

  // Reducer model: registered sum, LAT stages deep.
  always @(posedge clock) begin
    red[0] <= vsum(pipe_x);
    for (int k = 1; k < LAT; k++) red[k] <= red[k-1];
  end
  assign pipe_y = red[LAT-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int r, input logic [15:0] e);
    for (int k = 0; k < VECTOR_SIZE; k++) req_x[(r*VECTOR_SIZE + k)*16 +: 16] = e;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    tick();
    sb.delete();
    reset = 1'b0;
  endtask

  // Accept monitor: push expectation at the moment a transfer is committed.
  initial forever begin
    @(negedge clock);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        sb.push_back('{id: i, sum: vsum(req_x[i*VW +: VW]), due: cyc + LAT + 2});
      end
    end
  end

  // Response monitor: pop and compare id, sum and arrival cycle.
  initial forever begin
    sb_t e;
    @(negedge clock);
    if (resp_valid !== 4'b0000) begin
      n_resp++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected: got valid %b required none", resp_valid);
      end else begin
        e = sb.pop_front();
        chk("resp_id", 32'(resp_valid), 32'(1) << e.id);
        chk("resp_data", 32'(resp_data), 32'(e.sum));
        chk("resp_cycle", cyc, e.due);
      end
    end
  end

  task automatic single_shot(input int r, input logic [255:0] vec,
                             input logic [15:0] exp, input string nm);
    int c0;
    bit got;
    req_x[r*VW +: VW] = vec;
    req_valid = 4'b0001 << r;
    @(negedge clock);
    chk({nm, "_ready"}, 32'(req_ready), 32'(1) << r);
    c0 = cyc;
    tick();
    req_valid = '0;
    @(negedge clock);
    chk({nm, "_inflight1"}, 32'(inflight), 1);
    chk({nm, "_busy1"}, 32'(busy), 1);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (resp_valid !== 4'b0000) got = 1'b1;
    end
    chk({nm, "_timeout"}, 32'(got), 1);
    if (got) begin
      chk({nm, "_valid"}, 32'(resp_valid), 32'(1) << r);
      chk({nm, "_data"}, 32'(resp_data), 32'(exp));
      chk({nm, "_latency"}, cyc - c0, LAT + 2);
      chk({nm, "_inflight0"}, 32'(inflight), 0);
      chk({nm, "_busy0"}, 32'(busy), 0);
      tick();
      @(negedge clock);
      chk({nm, "_strobe1cyc"}, 32'(resp_valid), 0);
      chk({nm, "_hold"}, 32'(resp_data), 32'(exp));
    end
    tick();
  endtask

  initial begin
    logic [255:0] v;
    int n0;
    tbl[0]  = '{4'b0000, 4'b0000, 16'd3};
    tbl[1]  = '{4'b1111, 4'b0001, 16'd10};
    tbl[2]  = '{4'b1111, 4'b0010, 16'd20};
    tbl[3]  = '{4'b0001, 4'b0001, 16'd30};
    tbl[4]  = '{4'b1000, 4'b1000, 16'd40};
    tbl[5]  = '{4'b1100, 4'b0100, 16'd50};
    tbl[6]  = '{4'b0011, 4'b0001, 16'd60};
    tbl[7]  = '{4'b1001, 4'b1000, 16'd70};
    tbl[8]  = '{4'b1001, 4'b0001, 16'd80};
    tbl[9]  = '{4'b0110, 4'b0010, 16'd90};
    tbl[10] = '{4'b0010, 4'b0010, 16'h7FFF};
    tbl[11] = '{4'b0110, 4'b0100, 16'hF00D};

    // Reset state, with all requesters already asserting.
    req_x = '0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 16'(i + 1));
    req_valid = 4'b1111;
    @(negedge clock);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_pipe_x", 32'(|pipe_x), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_data", 32'(resp_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_inflight", 32'(inflight), 0);
    tick();
    reset = 1'b0;

    // Full contention: grants rotate 0..3, occupancy saturates at LAT+1.
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      chk($sformatf("cont_ready[%0d]", k), 32'(req_ready), 32'(1) << (k % 4));
      chk($sformatf("cont_inflight[%0d]", k), 32'(inflight), (k < 5) ? k : 5);
      tick();
    end
    req_valid = '0;
    drain(8);
    chk("cont_drain", sb.size(), 0);

    // Table-driven arbitration vectors from a fresh pointer.
    do_reset();
    for (int t = 0; t < 12; t++) begin
      req_valid = tbl[t].valid;
      for (int i = 0; i < NUM_REQ; i++) set_req(i, tbl[t].base + 16'(i));
      @(negedge clock);
      chk($sformatf("arb_ready[%0d]", t), 32'(req_ready), 32'(tbl[t].exp_ready));
      tick();
    end
    req_valid = '0;
    drain(8);
    chk("arb_drain", sb.size(), 0);

    // Single request and wrap-around sums.
    do_reset();
    v = '0;
    v[15:0] = 16'd4;
    v[31:16] = 16'd6;
    single_shot(2, v, 16'd10, "single");
    for (int e = 0; e < VECTOR_SIZE; e++) v[e*16 +: 16] = 16'hFFFF;
    single_shot(0, v, 16'hFFF0, "wrap_ffff");
    for (int e = 0; e < VECTOR_SIZE; e++) v[e*16 +: 16] = 16'h8000;
    single_shot(3, v, 16'h0000, "wrap_8000");

    // Lone requester: granted every cycle, ten back-to-back results.
    do_reset();
    n0 = n_resp;
    req_valid = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      set_req(1, 16'(k*3 + 1));
      @(negedge clock);
      chk($sformatf("lone_ready[%0d]", k), 32'(req_ready), 32'h2);
      tick();
    end
    req_valid = '0;
    drain(8);
    chk("lone_count", n_resp - n0, 10);

    // Reset mid-flight: dropped vectors never respond; pointer restarts at 0.
    do_reset();
    set_req(1, 16'd9);
    req_valid = 4'b0010;
    drain(3);
    req_valid = '0;
    drain(2);
    reset = 1'b1;
    tick();
    sb.delete();
    reset = 1'b0;
    n0 = n_resp;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 16'(i + 1));
    req_valid = 4'b1111;
    @(negedge clock);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_inflight", 32'(inflight), 0);
    chk("mid_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    drain(8);
    chk("mid_count", n_resp - n0, 1);
    chk("mid_busy_end", 32'(busy), 0);

    // Hold on loss: pointer at 3, requesters 0 and 3 pending.
    do_reset();
    set_req(2, 16'd5);
    req_valid = 4'b0100;
    tick();
    set_req(0, 16'd1);
    set_req(3, 16'd2);
    req_valid = 4'b1001;
    @(negedge clock);
    chk("hold_first", 32'(req_ready), 32'h8);
    tick();
    @(negedge clock);
    chk("hold_second", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    drain(8);
    chk("final_drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish before limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vreducesum_arbiter.md
# vreducesum_arbiter

Round-robin scheduler that shares one `vreducesum` pipeline between `NUM_REQ` requesters. It accepts one vector per cycle from the winning requester and drives it into the reducer. It tags each issued vector with its requester id in a shadow pipeline matched to the reducer depth, then returns each sum to its originator. It sits between the vector-producing units and the reducer instance, which it owns exclusively.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2.
- `VECTOR_SIZE`, 16: elements per vector; power of two, ≥2.
- `INT_SIZE`, 16: element and sum width.
- `LAT` (localparam), `$clog2(VECTOR_SIZE)`: reducer register depth.

Ports:
- `clock`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  `NUM_REQ`  requester i has a vector pending.
- `req_ready`  out  `NUM_REQ`  one-hot (or zero) grant; transfer when `req_valid[i] & req_ready[i]`.
- `req_x`  in  `NUM_REQ` × `VECTOR_SIZE` × `INT_SIZE`  per-requester vector.
- `pipe_x`  out  `VECTOR_SIZE` × `INT_SIZE`  registered vector to the reducer `x`.
- `pipe_y`  in  `INT_SIZE`  reducer output `y`.
- `resp_valid`  out  `NUM_REQ`  one-hot, single-cycle result strobe.
- `resp_data`  out  `INT_SIZE`  sum for the strobed requester.
- `busy`  out  1  any tag stage valid.
- `inflight`  out  `$clog2(LAT+3)`  number of valid tag stages.

## Operation
- **Arbitration** is combinational round-robin over `req_valid`, starting at priority pointer `ptr`.
  - `req_ready[g]` = 1 only for the first valid index at or after `ptr`, wrapping.
  - All `req_ready` bits are 0 when no request is valid or during `reset`.
  - `req_ready` may depend on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- **On accept of g:**
  - `ptr <= (g+1) mod NUM_REQ`.
  - `pipe_x <= req_x[g]`.
  - `tag[0] <= {1, g}`.
- **With no accept:**
  - `pipe_x <= 0`.
  - `tag[0] <= {0, x}`.
  - `ptr` is unchanged.
- **Tag shift:** there are `LAT+1` stages, and `tag[k] <= tag[k-1]` every cycle. There is no stall; the reducer cannot back-pressure.
- **Result return:**
  - When `tag[LAT]` is valid with id i, at the next edge `resp_valid <= onehot(i)` and `resp_data <= pipe_y`.
  - Otherwise `resp_valid <= 0`; `resp_data` holds its last value.
- **No result back-pressure:** requesters must sink `resp_valid` every cycle.
- **Arithmetic:** the sum is modulo 2^`INT_SIZE` (wrap-around), unsigned/two's-complement agnostic. No saturation and no overflow flag.
- **Counters:**
  - `inflight` = popcount of valid `tag[0..LAT]`.
  - `busy` = (`inflight` != 0).
  - The maximum value is `LAT+1`.
- **Reset** (synchronous, any cycle, including mid-flight):
  - `ptr`, `pipe_x`, all tags, `resp_valid` and `resp_data` go to 0.
  - In-flight vectors are dropped and no `resp_valid` is produced for them.
  - The reducer's own registers may hold stale data. This is harmless because they are untagged.
- **Reducer reset:** the reducer's `resetn` is tied high or driven from the system reset by the top level. The controller does not depend on it.

## Timing
- **Latency:** accept at edge n puts data on `pipe_x` after edge n and sets `tag[LAT]` after edge n+LAT (`pipe_y` valid). `resp_valid` is high for exactly the cycle after edge n+LAT+1.
  - This is `LAT+1` cycles (5 for `VECTOR_SIZE`=16).
- **Throughput:** one vector per cycle aggregate.
  - Results leave in issue order, one per cycle, with no gaps beyond input gaps.
- **Fairness:** with all requesters continuously valid, each is granted exactly once per `NUM_REQ` cycles.
- **Simultaneous events:**
  - A new accept and a result return on the same edge are independent.
  - A requester may receive a result and be granted again in the same cycle.
- **Reset values** (asserted the cycle after a reset edge):
  - `req_ready`=0 while reset is high.
  - `pipe_x`=0, `resp_valid`=0, `resp_data`=0, `busy`=0, `inflight`=0.

## Test plan
Defaults `NUM_REQ`=4, `VECTOR_SIZE`=16, `INT_SIZE`=16.
- **Single request:** requester 2 only, `x[0]`=4, `x[1]`=6, others 0.
  - Response: grant at edge n; `resp_valid`=4'b0100 and `resp_data`=10 in the cycle after edge n+5; `inflight` rises to 1 and returns to 0.
- **Full contention:** all four valid continuously from reset, requester i sends every element = i+1.
  - Response: grants 0,1,2,3,0,… back-to-back; results 16,32,48,64 repeating, one per cycle, matching ids.
  - `inflight` saturates at 5.
- **Wrap-around:** all elements 16'hFFFF.
  - Response: `resp_data`=16'hFFF0.
  - Separate case: elements alternate 16'h8000/16'h8000, giving `resp_data`=0.
- **Lone requester:** requester 1 valid every cycle, others idle.
  - Response: granted every cycle; `ptr` cycles but never blocks it; 10 consecutive results in 10 consecutive cycles.
- **Reset mid-flight:** issue 3 vectors on consecutive cycles, then assert `reset` for 1 cycle 2 cycles later.
  - Response: no `resp_valid` ever for those vectors; `busy`=0; next grant goes to requester 0 first under contention.
- **Hold on loss:** requesters 0 and 3 valid, `ptr`=3.
  - Response: 3 wins first, then 0.
  - The loser's `req_valid` and `req_x` stay stable until its grant, and its result carries its own data.
